hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 5-stage RV32 core. It works alongside the operand-forwarding logic and handles the hazards forwarding cannot cover:
  - load-use dependencies,
  - taken branches/jumps resolved in EX,
  - multi-cycle MUL/DIV unit (MDU) occupancy.
- Drives PC/IF-ID/ID-EX write enables, flush/bubble controls, the MDU start pulse, sticky error status and performance counters.

Parameters:
- MDU_MAX_CYCLES, 64, cycles in MDU_BUSY without mdu_done before timeout abort (>=2).
- CNT_W, 32, width of stall_count.
- FLUSH_W, 16, width of flush_count.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 of instruction in ID.
- id_rs2  in  5  rs2 of instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_ex_rd  in  5  rd of instruction in EX.
- id_ex_memread  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved taken branch/jump.
- ex_mdu_req  in  1  EX instruction is MUL/DIV.
- mdu_done  in  1  MDU result valid this cycle.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- if_id_flush  out  1  zero IF/ID (insert NOP).
- id_ex_flush  out  1  zero ID/EX control (bubble).
- ex_mem_bubble  out  1  load NOP into EX/MEM.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_busy  out  1  state == MDU_BUSY.
- mdu_timeout  out  1  sticky timeout flag.
- stall_count  out  CNT_W  cycles with pc_write=0.
- flush_count  out  FLUSH_W  taken-branch flush events.

Behaviour:
- States: RUN, MDU_BUSY. Reset (async) → RUN, cycle counter=0, mdu_timeout=0, stall_count=0, flush_count=0.
- Control outputs are combinational from state and inputs. Defaults: pc_write=if_id_write=id_ex_write=1, all flush/bubble/start=0.
- With all inputs 0 after reset, outputs equal the defaults.

RUN, evaluated in priority order:
1. ex_mdu_req=1: pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1, mdu_start=1.
   - If mdu_done=1 in the same cycle, the result is already valid: no stall, no start, stay RUN.
   - Otherwise next state MDU_BUSY, cycle counter=1.
   - ex_branch_taken is ignored while ex_mdu_req=1.
2. ex_branch_taken=1: if_id_flush=1, id_ex_flush=1, pc_write=1 (loads target); flush_count+1.
   - Overrides a simultaneous load-use condition, because the dependent instruction is squashed.
3. Load-use: id_ex_memread & id_ex_rd≠0 & ((id_uses_rs1 & id_ex_rd==id_rs1) | (id_uses_rs2 & id_ex_rd==id_rs2)).
   - Response: pc_write=0, if_id_write=0, id_ex_flush=1.
   - Exactly one bubble, since the load advances to MEM next cycle.

MDU_BUSY:
- pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1, mdu_start=0, cycle counter+1 each cycle.
- mdu_done=1: stalls released that cycle (all enables 1, ex_mem_bubble=0, so the result enters EX/MEM); next state RUN.
- Counter reaches MDU_MAX_CYCLES without done: mdu_timeout←1 (sticky until reset); stalls released that cycle; next state RUN.
- mdu_done takes precedence over timeout in the same cycle.
- ex_branch_taken and the load-use check are ignored.

Counters:
- stall_count increments on every clock where pc_write=0.
- Both counters saturate at all-ones and never wrap.

Reset mid-MDU_BUSY:
- Immediate return to RUN; outputs take their defaults asynchronously.
- The MDU is not notified; mdu_done in the first RUN cycle with ex_mdu_req=0 is ignored.

Test Plan:
- Load-use: id_ex_memread=1, id_ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle → pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_count=1. Repeat with id_ex_rd=0 → no stall.
- Branch vs load-use: load-use condition plus ex_branch_taken=1 → if_id_flush=id_ex_flush=1, pc_write=1; flush_count=1, stall_count unchanged.
- MDU: ex_mdu_req=1, mdu_done after 5 cycles → mdu_start pulses only in cycle 0; mdu_busy=1 cycles 1-5; stalls cycles 0-4; release in cycle 5; stall_count=5; state RUN.
- Timeout: MDU_MAX_CYCLES=8, ex_mdu_req=1, mdu_done never → mdu_timeout=1 when the counter reaches 8; stalls released; flag stays 1 through later traffic until reset.
- Async reset mid-MDU_BUSY (cycle 3): outputs return to defaults before the next clk edge; stall_count=0, mdu_busy=0.
- Saturation: preload via CNT_W=4, hold load-use 20 cycles → stall_count stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / branch-flush / MDU stall sequencer for the 5-stage RV32 pipeline
// Control outputs are combinational from state and inputs; counters and timeout flag are registered.
module hazard_ctrl #(
    parameter int MDU_MAX_CYCLES = 64,
    parameter int CNT_W          = 32,
    parameter int FLUSH_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic [4:0]         id_ex_rd,
    input  logic               id_ex_memread,
    input  logic               ex_branch_taken,
    input  logic               ex_mdu_req,
    input  logic               mdu_done,
    output logic               pc_write,
    output logic               if_id_write,
    output logic               id_ex_write,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               ex_mem_bubble,
    output logic               mdu_start,
    output logic               mdu_busy,
    output logic               mdu_timeout,
    output logic [CNT_W-1:0]   stall_count,
    output logic [FLUSH_W-1:0] flush_count
);

    localparam int CW = $clog2(MDU_MAX_CYCLES + 1);
    localparam logic [CW-1:0] CYC_LIMIT = CW'(MDU_MAX_CYCLES);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cyc, cyc_nx;
    logic          load_use;
    logic          timeout_set;
    logic          flush_evt;

    assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_ex_rd == id_rs1)) ||
                       (id_uses_rs2 && (id_ex_rd == id_rs2)));

    assign mdu_busy = (state == MDU_BUSY);

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        mdu_start     = 1'b0;
        state_nx      = state;
        cyc_nx        = cyc;
        timeout_set   = 1'b0;
        flush_evt     = 1'b0;
        case (state)
            RUN: begin
                if (ex_mdu_req) begin
                    // A same-cycle mdu_done means the result is already there: pass straight through.
                    if (!mdu_done) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        mdu_start     = 1'b1;
                        state_nx      = MDU_BUSY;
                        cyc_nx        = CW'(1);
                    end
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_evt   = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MDU_BUSY: begin
                if (mdu_done) begin
                    state_nx = RUN;
                end else if (cyc == CYC_LIMIT) begin
                    timeout_set = 1'b1;
                    state_nx    = RUN;
                end else begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_bubble = 1'b1;
                    cyc_nx        = cyc + CW'(1);
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            cyc         <= '0;
            mdu_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state <= state_nx;
            cyc   <= cyc_nx;
            if (timeout_set)
                mdu_timeout <= 1'b1;
            // Both counters saturate rather than wrap.
            if (!pc_write && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if (flush_evt && (flush_count != '1))
                flush_count <= flush_count + FLUSH_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (MDU_MAX_CYCLES=8, CNT_W=4)
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, id_ex_rd;
    logic        id_uses_rs1, id_uses_rs2, id_ex_memread;
    logic        ex_branch_taken, ex_mdu_req, mdu_done;
    logic        pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush;
    logic        ex_mem_bubble, mdu_start, mdu_busy, mdu_timeout;
    logic [3:0]  stall_count;
    logic [15:0] flush_count;

    hazard_ctrl #(.MDU_MAX_CYCLES(8), .CNT_W(4), .FLUSH_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_memread(id_ex_memread),
        .ex_branch_taken(ex_branch_taken), .ex_mdu_req(ex_mdu_req), .mdu_done(mdu_done),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_bubble(ex_mem_bubble), .mdu_start(mdu_start),
        .mdu_busy(mdu_busy), .mdu_timeout(mdu_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_bubble, mdu_start, mdu_busy, mdu_timeout}
    localparam logic [8:0] DEF  = 9'b111_00_00_0_0;
    localparam logic [8:0] LU   = 9'b001_01_00_0_0;
    localparam logic [8:0] BR   = 9'b111_11_00_0_0;
    localparam logic [8:0] MST  = 9'b000_00_11_0_0;
    localparam logic [8:0] BSY  = 9'b000_00_10_1_0;
    localparam logic [8:0] REL  = 9'b111_00_00_1_0;
    localparam logic [8:0] TO   = 9'b000_00_00_0_1;

    typedef struct {
        string      name;
        logic [8:0] ctrl;
        int         sc;
        int         fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] act;
            e   = exp_q.pop_front();
            act = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush,
                   ex_mem_bubble, mdu_start, mdu_busy, mdu_timeout};
            checks++;
            if (act !== e.ctrl || int'(stall_count) != e.sc || int'(flush_count) != e.fc) begin
                failures++;
                $display("FAIL %s: ctrl=%b stall=%0d flush=%0d, expected ctrl=%b stall=%0d flush=%0d",
                         e.name, act, stall_count, flush_count, e.ctrl, e.sc, e.fc);
            end
        end
    end

    task automatic clear_in();
        id_rs1 = 0; id_rs2 = 0; id_ex_rd = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_ex_memread = 0;
        ex_branch_taken = 0; ex_mdu_req = 0; mdu_done = 0;
    endtask

    task automatic expect_cycle(input string name, input logic [8:0] ctrl, input int sc, input int fc);
        exp_t e;
        e.name = name; e.ctrl = ctrl; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_load_use();
        id_ex_memread = 1; id_ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        #2;
        expect_cycle("reset_held", DEF, 0, 0);
        do_reset();
        expect_cycle("idle_defaults", DEF, 0, 0);

        set_load_use();
        expect_cycle("load_use_rs1", LU, 0, 0);
        clear_in();
        expect_cycle("after_load_use", DEF, 1, 0);
        set_load_use(); id_ex_rd = 0; id_rs1 = 0;
        expect_cycle("load_use_rd0", DEF, 1, 0);
        clear_in();
        id_ex_memread = 1; id_ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1; id_rs1 = 3;
        expect_cycle("load_use_rs2", LU, 1, 0);
        id_uses_rs2 = 0;
        expect_cycle("rs2_not_used", DEF, 2, 0);
        id_uses_rs2 = 1; id_ex_memread = 0;
        expect_cycle("not_a_load", DEF, 2, 0);

        clear_in();
        set_load_use(); ex_branch_taken = 1;
        expect_cycle("branch_over_load_use", BR, 2, 0);
        clear_in();
        expect_cycle("after_branch", DEF, 2, 1);

        do_reset();
        ex_mdu_req = 1;
        expect_cycle("mdu_cycle0", MST, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            ex_mdu_req = (k == 1);
            ex_branch_taken = (k == 2);
            if (k == 2) set_load_use();
            expect_cycle($sformatf("mdu_busy_c%0d", k), BSY, k, 0);
            clear_in();
        end
        mdu_done = 1;
        expect_cycle("mdu_release_c5", REL, 5, 0);
        clear_in();
        expect_cycle("mdu_back_run", DEF, 5, 0);
        ex_mdu_req = 1; mdu_done = 1;
        expect_cycle("mdu_req_with_done", DEF, 5, 0);
        clear_in();
        expect_cycle("mdu_req_with_done_next", DEF, 5, 0);

        do_reset();
        ex_mdu_req = 1;
        expect_cycle("to_cycle0", MST, 0, 0);
        clear_in();
        for (int k = 1; k <= 7; k++)
            expect_cycle($sformatf("to_busy_c%0d", k), BSY, k, 0);
        expect_cycle("to_release_c8", REL, 8, 0);
        expect_cycle("to_flag_set", DEF | TO, 8, 0);
        set_load_use();
        expect_cycle("to_sticky_load_use", LU | TO, 8, 0);
        clear_in();
        expect_cycle("to_sticky_idle", DEF | TO, 9, 0);

        do_reset();
        expect_cycle("to_cleared_by_reset", DEF, 0, 0);
        ex_mdu_req = 1;
        expect_cycle("done_vs_to_c0", MST, 0, 0);
        clear_in();
        for (int k = 1; k <= 7; k++)
            expect_cycle($sformatf("done_vs_to_c%0d", k), BSY, k, 0);
        mdu_done = 1;
        expect_cycle("done_vs_to_c8", REL, 8, 0);
        clear_in();
        expect_cycle("done_wins_no_flag", DEF, 8, 0);

        do_reset();
        ex_mdu_req = 1;
        expect_cycle("ar_cycle0", MST, 0, 0);
        clear_in();
        expect_cycle("ar_busy_c1", BSY, 1, 0);
        expect_cycle("ar_busy_c2", BSY, 2, 0);
        #1;
        reset = 1'b1;
        expect_cycle("ar_async_defaults", DEF, 0, 0);
        reset = 1'b0;
        mdu_done = 1;
        expect_cycle("ar_stray_done_ignored", DEF, 0, 0);
        clear_in();

        do_reset();
        set_load_use();
        for (int k = 0; k < 20; k++)
            expect_cycle($sformatf("sat_c%0d", k), LU, (k > 15) ? 15 : k, 0);
        clear_in();
        expect_cycle("sat_final", DEF, 15, 0);

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: pending=%0d, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
